pulse_meter: RTL and testbench
==============================

Name: pulse_meter

Overview:
- Downstream consumer of the pulse-shaping stage in the F3 path. It watches Pulse_X and Pulse_Y and measures, per channel, the period and high time in sysclk cycles. It also measures the X-rise to Y-rise delay.
- Results go to the display/readback logic, so the shaped waveforms can be confirmed on-board without a scope.
- Measurement runs only while Enable_F3 is high.

Parameters:
CNT_W, 24, width of every measurement counter and result bus
TIMEOUT, 24'd5_000_000, cycles without a rising edge before a channel is declared stalled (100 ms at 50 MHz)

Ports:
sysclk  input  1  system clock; all logic on its rising edge
rst_n  input  1  reset, synchronous, active-low
Enable_F3  input  1  measurement enable (level)
Pulse_X  input  1  shaped pulse X, asynchronous to sysclk
Pulse_Y  input  1  shaped pulse Y, asynchronous to sysclk
Period_X  output  CNT_W  last X period, in cycles
High_X  output  CNT_W  last X high time, in cycles
Valid_X  output  1  one-cycle strobe: new X result
Timeout_X  output  1  X stalled (sticky until next Valid_X)
Period_Y  output  CNT_W  as Period_X, for channel Y
High_Y  output  CNT_W  as High_X, for channel Y
Valid_Y  output  1  as Valid_X, for channel Y
Timeout_Y  output  1  as Timeout_X, for channel Y
Phase_XY  output  CNT_W  cycles from X rise to the following Y rise
Phase_Valid  output  1  one-cycle strobe: new Phase_XY

Behaviour:
- Reset (rst_n=0 at a sysclk edge): all outputs 0, FSMs to IDLE, counters 0, synchronizer flops 0.
- Input conditioning:
  - Each pulse input goes through a 2-flop synchronizer, then a previous-value register.
  - rise = sync & ~prev; fall = ~sync & prev.
  - The edge is visible 3 sysclk edges after the pin is first sampled high.
- Per-channel FSM:
  - IDLE: counters held at 0. On rise, go to MEAS with cnt=1, hi=1.
  - MEAS, every cycle: cnt+1; hi+1 while sync=1; hi freezes on fall.
  - MEAS, on rise: Period<=cnt, High<=hi, Valid=1 for that cycle, Timeout<=0. Then cnt<=1, hi<=1 and stay in MEAS.
  - Result: a waveform with P cycles period and H cycles high reports Period=P, High=H exactly.
  - MEAS, when cnt reaches TIMEOUT with no rise: Timeout<=1, Period<=0, High<=0, no Valid, go to IDLE.
  - Constant-high and constant-low inputs both time out.
- Phase unit:
  - Arms on an X rise and clears pcnt (pcnt=0 in the X-rise cycle), then counts each cycle.
  - On a Y rise while armed: Phase_XY<=pcnt, Phase_Valid=1, disarm.
  - A second X rise before a Y rise re-arms and restarts pcnt; no strobe.
  - A Y rise while unarmed is ignored.
  - X and Y rising in the same cycle: Phase_XY=0, Phase_Valid=1.
  - pcnt reaching TIMEOUT disarms silently.
- Enable_F3=0:
  - Synchronous abort of both FSMs and the phase unit to IDLE/unarmed; counters cleared; strobes forced 0.
  - Result and Timeout registers hold their values.
  - On re-enable, the first rise only starts a measurement; no partial result is ever reported.
- Counters never wrap: TIMEOUT < 2^CNT_W - 1 is a requirement; an elaboration-time check fails otherwise.
- Strobes are exactly one cycle wide. Result buses change only in the cycle their strobe is high, or on timeout/reset.

Decomposition:
- No shared package needed; CNT_W and TIMEOUT are parameters, and FSM state encodings stay local.
- One sub-module, pulse_chan_meter: synchronizer, edge detect, FSM, Period/High/Valid/Timeout for one channel.
  - It exports its rise strobe for the phase unit.
  - pulse_meter instantiates it twice and adds the phase unit and the enable gating.

Test Plan:
- Reset, then X with period 10 and high 4, Enable_F3=1 → from the 2nd rise on, Valid_X pulses every 10 cycles with Period_X=10, High_X=4; outputs are 0 before that.
- Y equal to X delayed by 3 cycles → Phase_Valid once per period with Phase_XY=3; X and Y in phase → Phase_XY=0.
- X held high with TIMEOUT=100 (override) → Timeout_X=1, Period_X=0, High_X=0 at cnt=100, no Valid_X; restart pulses at period 20 → the 2nd rise gives Valid_X, Period_X=20, Timeout_X=0.
- Enable_F3 dropped mid-period, then restored → no Valid in between; results hold; the first rise after re-enable gives no strobe, and the second gives the correct period.
- Two X rises (period 8) with no Y rise, then a Y rise 2 cycles after the second X rise → a single Phase_Valid with Phase_XY=2.
- rst_n asserted low mid-measurement for 1 cycle → all outputs 0 on the next edge; measurement restarts cleanly.

Source files
------------

// File: rtl/pulse_meter_pkg.sv
// Shared defaults and an elaboration-time helper for the pulse_meter slice.
package pulse_meter_pkg;

    localparam int              CNT_W_DEF   = 24;
    localparam longint unsigned TIMEOUT_DEF = 64'd5_000_000;

    // A limit is usable only if a counter of this width reaches it without ever hitting all-ones.
    function automatic bit timeoutFits(input int width, input longint unsigned limit);
        return (limit > 0) && (width > 0) && (width < 64) &&
               (limit < ((64'd1 << width) - 64'd1));
    endfunction

endpackage

// File: rtl/pulse_chan_meter.sv
// One pulse channel: input synchronizer, edge detect and period/high-time measurement FSM.
module pulse_chan_meter
    import pulse_meter_pkg::*;
#(
    parameter int              CNT_W   = CNT_W_DEF,
    parameter longint unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             pulse_i,
    output logic             rise_o,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic             timeout_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    if (!timeoutFits(CNT_W, TIMEOUT)) begin : gen_timeout_check
        $error("pulse_chan_meter: TIMEOUT must be nonzero and below 2**CNT_W - 1");
    end

    typedef enum logic {
        IDLE,
        MEAS
    } chanState_e;

    chanState_e       state_q;
    logic             pulseMeta_q;
    logic             pulseSync_q;
    logic             pulsePrev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] hi_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_q;
    logic             valid_q;
    logic             timeout_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] hi_d;

    assign rise_o = pulseSync_q & ~pulsePrev_q;
    assign cnt_d  = cnt_q + CNT_W'(1);
    assign hi_d   = pulseSync_q ? (hi_q + CNT_W'(1)) : hi_q;

    // The synchronizer keeps running while disabled so re-enable sees a settled level.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pulseMeta_q <= 1'b0;
            pulseSync_q <= 1'b0;
            pulsePrev_q <= 1'b0;
        end else begin
            pulseMeta_q <= pulse_i;
            pulseSync_q <= pulseMeta_q;
            pulsePrev_q <= pulseSync_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else if (!en_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise_o) begin
                        state_q <= MEAS;
                        cnt_q   <= CNT_W'(1);
                        hi_q    <= CNT_W'(1);
                    end
                end
                MEAS: begin
                    // A rise closes one period and opens the next in the same cycle.
                    if (rise_o) begin
                        period_q  <= cnt_q;
                        high_q    <= hi_q;
                        valid_q   <= 1'b1;
                        timeout_q <= 1'b0;
                        cnt_q     <= CNT_W'(1);
                        hi_q      <= CNT_W'(1);
                    end else if (cnt_q == LIMIT) begin
                        state_q   <= IDLE;
                        timeout_q <= 1'b1;
                        period_q  <= '0;
                        high_q    <= '0;
                        cnt_q     <= '0;
                        hi_q      <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                        hi_q  <= hi_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    hi_q    <= '0;
                end
            endcase
        end
    end

    assign period_o  = period_q;
    assign high_o    = high_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;

endmodule

// File: rtl/pulse_meter.sv
// Two-channel pulse meter: per-channel period/high time plus the X-rise to Y-rise delay.
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int              CNT_W   = CNT_W_DEF,
    parameter longint unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             Enable_F3,
    input  logic             Pulse_X,
    input  logic             Pulse_Y,
    output logic [CNT_W-1:0] Period_X,
    output logic [CNT_W-1:0] High_X,
    output logic             Valid_X,
    output logic             Timeout_X,
    output logic [CNT_W-1:0] Period_Y,
    output logic [CNT_W-1:0] High_Y,
    output logic             Valid_Y,
    output logic             Timeout_Y,
    output logic [CNT_W-1:0] Phase_XY,
    output logic             Phase_Valid
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic {
        UNARMED,
        ARMED
    } phaseState_e;

    logic             riseX;
    logic             riseY;
    phaseState_e      phaseState_q;
    logic [CNT_W-1:0] pcnt_q;
    logic [CNT_W-1:0] pcnt_d;
    logic [CNT_W-1:0] phase_q;
    logic             phaseValid_q;

    pulse_chan_meter #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) u_chan_x (
        .clk_i    (sysclk),
        .rst_ni   (rst_n),
        .en_i     (Enable_F3),
        .pulse_i  (Pulse_X),
        .rise_o   (riseX),
        .period_o (Period_X),
        .high_o   (High_X),
        .valid_o  (Valid_X),
        .timeout_o(Timeout_X)
    );

    pulse_chan_meter #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) u_chan_y (
        .clk_i    (sysclk),
        .rst_ni   (rst_n),
        .en_i     (Enable_F3),
        .pulse_i  (Pulse_Y),
        .rise_o   (riseY),
        .period_o (Period_Y),
        .high_o   (High_Y),
        .valid_o  (Valid_Y),
        .timeout_o(Timeout_Y)
    );

    assign pcnt_d = pcnt_q + CNT_W'(1);

    // The X-rise cycle itself counts as delay 0, so the counter is loaded with 1 for the next cycle.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            phaseState_q <= UNARMED;
            pcnt_q       <= '0;
            phase_q      <= '0;
            phaseValid_q <= 1'b0;
        end else if (!Enable_F3) begin
            phaseState_q <= UNARMED;
            pcnt_q       <= '0;
            phaseValid_q <= 1'b0;
        end else begin
            phaseValid_q <= 1'b0;
            if (riseX && riseY) begin
                phaseState_q <= UNARMED;
                phase_q      <= '0;
                phaseValid_q <= 1'b1;
                pcnt_q       <= '0;
            end else if (riseX) begin
                phaseState_q <= ARMED;
                pcnt_q       <= CNT_W'(1);
            end else if (phaseState_q == ARMED) begin
                if (riseY) begin
                    phaseState_q <= UNARMED;
                    phase_q      <= pcnt_q;
                    phaseValid_q <= 1'b1;
                    pcnt_q       <= '0;
                end else if (pcnt_q == LIMIT) begin
                    phaseState_q <= UNARMED;
                    pcnt_q       <= '0;
                end else begin
                    pcnt_q <= pcnt_d;
                end
            end
        end
    end

    assign Phase_XY    = phase_q;
    assign Phase_Valid = phaseValid_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Randomised bench for pulse_meter, checked each cycle against an edge-timestamp reference model.
module tb_pulse_meter;

    localparam int CNT_W   = 24;
    localparam int TIMEOUT = 100;

    logic             sysclk = 1'b0;
    logic             rst_n;
    logic             Enable_F3;
    logic             Pulse_X;
    logic             Pulse_Y;
    logic [CNT_W-1:0] Period_X;
    logic [CNT_W-1:0] High_X;
    logic             Valid_X;
    logic             Timeout_X;
    logic [CNT_W-1:0] Period_Y;
    logic [CNT_W-1:0] High_Y;
    logic             Valid_Y;
    logic             Timeout_Y;
    logic [CNT_W-1:0] Phase_XY;
    logic             Phase_Valid;

    pulse_meter #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .Enable_F3  (Enable_F3),
        .Pulse_X    (Pulse_X),
        .Pulse_Y    (Pulse_Y),
        .Period_X   (Period_X),
        .High_X     (High_X),
        .Valid_X    (Valid_X),
        .Timeout_X  (Timeout_X),
        .Period_Y   (Period_Y),
        .High_Y     (High_Y),
        .Valid_Y    (Valid_Y),
        .Timeout_Y  (Timeout_Y),
        .Phase_XY   (Phase_XY),
        .Phase_Valid(Phase_Valid)
    );

    always #5 sysclk = ~sysclk;

    int     checkCount = 0;
    int     passCount  = 0;
    longint cyc        = 0;

    // Waveform description per channel: mode 0 low, 1 high, 2 periodic (period, high, offset).
    int wMode [2];
    int wPer  [2];
    int wHigh [2];
    longint wOff [2];

    // Reference model: pin history through the 3-edge latency, then timestamps of visible edges.
    logic             hist    [2][4];
    bit               mMeas   [2];
    longint           mRiseAt [2];
    longint           mFallAt [2];
    logic [CNT_W-1:0] mPeriod [2];
    logic [CNT_W-1:0] mHigh   [2];
    logic             mValid  [2];
    logic             mTimeout[2];
    bit               mArmed;
    longint           mArmAt;
    logic [CNT_W-1:0] mPhase;
    logic             mPhaseValid;

    function automatic logic pinLevel(input int ch, input longint c);
        longint ph;
        if (wMode[ch] == 0) return 1'b0;
        if (wMode[ch] == 1) return 1'b1;
        ph = ((c - wOff[ch]) % wPer[ch] + wPer[ch]) % wPer[ch];
        return (ph < wHigh[ch]);
    endfunction

    task automatic setWave(input int ch, input int mode, input int per, input int hi, input longint off);
        wMode[ch] = mode;
        wPer[ch]  = per;
        wHigh[ch] = hi;
        wOff[ch]  = off;
    endtask

    task automatic randomWave(input int ch);
        int r;
        int per;
        r   = int'($urandom_range(0, 9));
        per = (r < 8) ? int'($urandom_range(2, 40)) : int'($urandom_range(90, 130));
        setWave(ch, (r == 0) ? 0 : ((r == 1) ? 1 : 2), per,
                int'($urandom_range(1, per - 1)), cyc + longint'($urandom_range(0, per - 1)));
    endtask

    task automatic modelEdge();
        logic pin [2];
        logic rise[2];
        pin[0] = Pulse_X;
        pin[1] = Pulse_Y;
        if (!rst_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                for (int j = 0; j < 4; j++) hist[ch][j] = 1'b0;
                mMeas[ch]    = 1'b0;
                mPeriod[ch]  = '0;
                mHigh[ch]    = '0;
                mValid[ch]   = 1'b0;
                mTimeout[ch] = 1'b0;
            end
            mArmed      = 1'b0;
            mPhase      = '0;
            mPhaseValid = 1'b0;
            return;
        end
        for (int ch = 0; ch < 2; ch++) begin
            hist[ch][3] = hist[ch][2];
            hist[ch][2] = hist[ch][1];
            hist[ch][1] = hist[ch][0];
            hist[ch][0] = pin[ch];
            rise[ch] = hist[ch][2] & ~hist[ch][3];
            if (!hist[ch][2] && hist[ch][3]) mFallAt[ch] = cyc;
            mValid[ch] = 1'b0;
            if (!Enable_F3) begin
                mMeas[ch] = 1'b0;
            end else if (rise[ch]) begin
                if (mMeas[ch]) begin
                    mValid[ch]   = 1'b1;
                    mPeriod[ch]  = CNT_W'(cyc - mRiseAt[ch]);
                    mHigh[ch]    = CNT_W'(mFallAt[ch] - mRiseAt[ch]);
                    mTimeout[ch] = 1'b0;
                end
                mMeas[ch]   = 1'b1;
                mRiseAt[ch] = cyc;
            end else if (mMeas[ch] && (cyc - mRiseAt[ch] == TIMEOUT)) begin
                mTimeout[ch] = 1'b1;
                mPeriod[ch]  = '0;
                mHigh[ch]    = '0;
                mMeas[ch]    = 1'b0;
            end
        end
        mPhaseValid = 1'b0;
        if (!Enable_F3) begin
            mArmed = 1'b0;
        end else if (rise[0] && rise[1]) begin
            mPhase      = '0;
            mPhaseValid = 1'b1;
            mArmed      = 1'b0;
        end else if (rise[0]) begin
            mArmed = 1'b1;
            mArmAt = cyc;
        end else if (mArmed && rise[1]) begin
            mPhase      = CNT_W'(cyc - mArmAt);
            mPhaseValid = 1'b1;
            mArmed      = 1'b0;
        end else if (mArmed && (cyc - mArmAt == TIMEOUT)) begin
            mArmed = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    endtask

    task automatic checkAll();
        checkOutput("Period_X",    Period_X,           mPeriod[0]);
        checkOutput("High_X",      High_X,             mHigh[0]);
        checkOutput("Valid_X",     CNT_W'(Valid_X),    CNT_W'(mValid[0]));
        checkOutput("Timeout_X",   CNT_W'(Timeout_X),  CNT_W'(mTimeout[0]));
        checkOutput("Period_Y",    Period_Y,           mPeriod[1]);
        checkOutput("High_Y",      High_Y,             mHigh[1]);
        checkOutput("Valid_Y",     CNT_W'(Valid_Y),    CNT_W'(mValid[1]));
        checkOutput("Timeout_Y",   CNT_W'(Timeout_Y),  CNT_W'(mTimeout[1]));
        checkOutput("Phase_XY",    Phase_XY,           mPhase);
        checkOutput("Phase_Valid", CNT_W'(Phase_Valid), CNT_W'(mPhaseValid));
    endtask

    // Pins change 1 time unit after each edge; outputs are compared 1 time unit after the edge.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            Pulse_X = pinLevel(0, cyc);
            Pulse_Y = pinLevel(1, cyc);
            @(posedge sysclk);
            modelEdge();
            #1;
            checkAll();
            cyc++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        Enable_F3 = 1'b0;
        Pulse_X   = 1'b0;
        Pulse_Y   = 1'b0;
        mFallAt[0] = 0;
        mFallAt[1] = 0;
        mRiseAt[0] = 0;
        mRiseAt[1] = 0;
        mArmAt     = 0;
        setWave(0, 0, 1, 0, 0);
        setWave(1, 0, 1, 0, 0);
        applyStimulus(3);
        checkOutput("resetPeriodX", Period_X, 0);
        checkOutput("resetPhase",   Phase_XY, 0);

        $display("[TB] X period 10 high 4, Y delayed by 3");
        rst_n     = 1'b1;
        Enable_F3 = 1'b1;
        setWave(0, 2, 10, 4, cyc + 2);
        setWave(1, 2, 10, 4, cyc + 5);
        applyStimulus(60);
        checkOutput("planPeriodX", Period_X, 10);
        checkOutput("planHighX",   High_X,   4);
        checkOutput("planPeriodY", Period_Y, 10);
        checkOutput("planPhase3",  Phase_XY, 3);

        $display("[TB] X and Y in phase");
        setWave(1, 2, 10, 4, wOff[0]);
        applyStimulus(40);
        checkOutput("planPhase0", Phase_XY, 0);

        $display("[TB] X stuck high, Y stuck low");
        setWave(0, 1, 1, 0, 0);
        setWave(1, 0, 1, 0, 0);
        applyStimulus(130);
        checkOutput("planTimeoutX", CNT_W'(Timeout_X), 1);
        checkOutput("planTimeoutY", CNT_W'(Timeout_Y), 1);
        checkOutput("planTimeoutPeriodX", Period_X, 0);
        checkOutput("planTimeoutHighX",   High_X,   0);

        $display("[TB] X restarts at period 20");
        setWave(0, 2, 20, 7, cyc + 2);
        applyStimulus(60);
        checkOutput("planPeriod20", Period_X, 20);
        checkOutput("planHigh7",    High_X,   7);
        checkOutput("planTimeoutCleared", CNT_W'(Timeout_X), 0);

        $display("[TB] enable dropped mid-period");
        setWave(0, 2, 12, 5, cyc + 2);
        setWave(1, 2, 12, 5, cyc + 2);
        applyStimulus(40);
        Enable_F3 = 1'b0;
        applyStimulus(15);
        checkOutput("planHoldPeriodX", Period_X, 12);
        Enable_F3 = 1'b1;
        applyStimulus(50);
        checkOutput("planReenPeriodX", Period_X, 12);
        checkOutput("planReenHighX",   High_X,   5);

        $display("[TB] two X rises before a Y rise");
        setWave(0, 2, 8, 2, cyc + 2);
        setWave(1, 2, 16, 3, cyc + 12);
        applyStimulus(70);
        checkOutput("planPhase2", Phase_XY, 2);

        $display("[TB] one-cycle reset mid-measurement");
        applyStimulus(5);
        rst_n = 1'b0;
        applyStimulus(1);
        checkOutput("planMidResetPeriodX", Period_X, 0);
        checkOutput("planMidResetPhase",   Phase_XY, 0);
        rst_n = 1'b1;
        applyStimulus(50);
        checkOutput("planAfterResetPeriodX", Period_X, 8);
        checkOutput("planAfterResetPhase",   Phase_XY, 2);

        $display("[TB] randomized waveforms");
        for (int ph = 0; ph < 25; ph++) begin
            randomWave(0);
            if ($urandom_range(0, 2) == 0 && wMode[0] == 2)
                setWave(1, 2, wPer[0], wHigh[0], wOff[0] + longint'($urandom_range(0, wPer[0] - 1)));
            else
                randomWave(1);
            Enable_F3 = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 9) == 0) begin
                rst_n = 1'b0;
                applyStimulus(1);
                rst_n = 1'b1;
            end
            applyStimulus(int'($urandom_range(40, 200)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
